divider_pipelined_array: RTL and testbench

- Fully pipelined unsigned restoring array divider; the inverse of the team's pipelined array multiplier.
- Each pipeline stage resolves one quotient bit, MSB first. The block accepts one operation per cycle, with a valid bit travelling alongside the data.
- Sits in the sequential arithmetic exercise set next to the multipliers. Round-trip benches feed multiplier products back through it.

---
 rtl/divider_pipelined_array.sv | 138 +++++++++++++
 tb/tb_divider_pipelined_array.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/divider_pipelined_array.sv
// Fully pipelined unsigned restoring array divider.
// Each stage resolves one quotient bit, MSB first. One operation can be
// accepted per cycle, and a valid bit travels with each operation.
// Results appear INPUT_WIDTH cycles after the input is accepted.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   in_valid     dividend/divisor are valid this cycle
//   dividend     unsigned dividend  [INPUT_WIDTH]
//   divisor      unsigned divisor   [INPUT_WIDTH]
//   out_valid    quotient/remainder/div_by_zero are valid this cycle
//   quotient     unsigned quotient  [INPUT_WIDTH]
//   remainder    unsigned remainder [INPUT_WIDTH]
//   div_by_zero  the divisor of this result was zero
module divider_pipelined_array #(
  parameter int unsigned INPUT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [INPUT_WIDTH-1:0] dividend,
  input  logic [INPUT_WIDTH-1:0] divisor,
  output logic                   out_valid,
  output logic [INPUT_WIDTH-1:0] quotient,
  output logic [INPUT_WIDTH-1:0] remainder,
  output logic                   div_by_zero
);

  localparam int unsigned W       = INPUT_WIDTH;
  localparam int unsigned RW      = W + 1;  // partial remainder width
  localparam int unsigned TW      = W + 2;  // trial value width
  localparam int unsigned LATENCY = W;
  localparam int unsigned LAST    = LATENCY - 1;

  // Per-stage register banks
  logic          vld_q [LATENCY];
  logic [RW-1:0] rem_q [LATENCY];
  logic [W-1:0]  dsr_q [LATENCY];
  logic [W-1:0]  dnd_q [LATENCY];
  logic [W-1:0]  quo_q [LATENCY];
  logic          dbz_q [LATENCY];

  logic          vld_d [LATENCY];
  logic [RW-1:0] rem_d [LATENCY];
  logic [W-1:0]  dsr_d [LATENCY];
  logic [W-1:0]  dnd_d [LATENCY];
  logic [W-1:0]  quo_d [LATENCY];
  logic          dbz_d [LATENCY];

  // One restoring step per stage: shift in the next dividend bit,
  // subtract the divisor when it fits, record the quotient bit.
  always_comb begin
    logic          v_in;
    logic [RW-1:0] r_in;
    logic [W-1:0]  d_in;
    logic [W-1:0]  n_in;
    logic [W-1:0]  q_in;
    logic          z_in;
    logic [TW-1:0] trial;
    logic          fits;

    v_in  = 1'b0;
    r_in  = '0;
    d_in  = '0;
    n_in  = '0;
    q_in  = '0;
    z_in  = 1'b0;
    trial = '0;
    fits  = 1'b0;

    for (int s = 0; s < int'(LATENCY); s++) begin
      vld_d[s] = 1'b0;
      rem_d[s] = '0;
      dsr_d[s] = '0;
      dnd_d[s] = '0;
      quo_d[s] = '0;
      dbz_d[s] = 1'b0;

      if (s == 0) begin
        // Stage 0 starts from a zero partial remainder and takes the ports.
        v_in = in_valid;
        r_in = '0;
        d_in = divisor;
        n_in = dividend;
        q_in = '0;
        z_in = (divisor == '0);
      end else begin
        v_in = vld_q[s-1];
        r_in = rem_q[s-1];
        d_in = dsr_q[s-1];
        n_in = dnd_q[s-1];
        q_in = quo_q[s-1];
        z_in = dbz_q[s-1];
      end

      trial = {r_in, n_in[W-1]};
      fits  = (trial >= TW'(d_in));

      vld_d[s] = v_in;
      rem_d[s] = fits ? RW'(trial - TW'(d_in)) : RW'(trial);
      dsr_d[s] = d_in;
      dnd_d[s] = n_in << 1;
      quo_d[s] = (q_in << 1) | W'(fits);
      dbz_d[s] = z_in;
    end
  end

  // Stage registers; data follows bubbles, only the valid bit gates results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(LATENCY); s++) begin
        vld_q[s] <= 1'b0;
        rem_q[s] <= '0;
        dsr_q[s] <= '0;
        dnd_q[s] <= '0;
        quo_q[s] <= '0;
        dbz_q[s] <= 1'b0;
      end
    end else begin
      for (int s = 0; s < int'(LATENCY); s++) begin
        vld_q[s] <= vld_d[s];
        rem_q[s] <= rem_d[s];
        dsr_q[s] <= dsr_d[s];
        dnd_q[s] <= dnd_d[s];
        quo_q[s] <= quo_d[s];
        dbz_q[s] <= dbz_d[s];
      end
    end
  end

  // Outputs come straight from the last stage's registers.
  assign out_valid   = vld_q[LAST];
  assign quotient    = quo_q[LAST];
  assign remainder   = rem_q[LAST][W-1:0];
  assign div_by_zero = dbz_q[LAST];

endmodule

// File: tb/tb_divider_pipelined_array.sv
// Self-checking bench for divider_pipelined_array (W=8 and W=16 instances).
module tb_divider_pipelined_array;

  localparam int unsigned W  = 8;
  localparam int unsigned W2 = 16;
  localparam int unsigned LAT = W;
  localparam int unsigned LAT2 = W2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic          in_valid;
  logic [W-1:0]  dividend, divisor;
  logic          out_valid;
  logic [W-1:0]  quotient, remainder;
  logic          div_by_zero;

  logic          in_valid2;
  logic [W2-1:0] dividend2, divisor2;
  logic          out_valid2;
  logic [W2-1:0] quotient2, remainder2;
  logic          div_by_zero2;

  divider_pipelined_array #(.INPUT_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  divider_pipelined_array #(.INPUT_WIDTH(W2)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2),
    .dividend(dividend2), .divisor(divisor2),
    .out_valid(out_valid2), .quotient(quotient2),
    .remainder(remainder2), .div_by_zero(div_by_zero2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] n;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Single operation: pulse in_valid once, expect exactly one result 8 edges later.
  task automatic run_single(input vec_t v);
    logic early;
    early = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; dividend = v.n; divisor = v.d;
    @(negedge clk);
    in_valid = 1'b0;
    early = early | out_valid;
    for (int k = 2; k < int'(LAT); k++) begin
      @(negedge clk);
      early = early | out_valid;
    end
    chk($sformatf("early_valid %0d/%0d", v.n, v.d), 32'(early), 32'd0);
    @(negedge clk);
    chk($sformatf("out_valid %0d/%0d", v.n, v.d), 32'(out_valid), 32'd1);
    chk($sformatf("quotient %0d/%0d", v.n, v.d), 32'(quotient), 32'(v.q));
    chk($sformatf("remainder %0d/%0d", v.n, v.d), 32'(remainder), 32'(v.r));
    chk($sformatf("dbz %0d/%0d", v.n, v.d), 32'(div_by_zero), 32'(v.z));
    @(negedge clk);
    chk($sformatf("single_pulse %0d/%0d", v.n, v.d), 32'(out_valid), 32'd0);
  endtask

  logic         vpat[$];
  logic [W-1:0] npat[$];
  logic [W-1:0] dpat[$];

  initial begin
    vecs[0] = '{n: 8'd200, d: 8'd7,   q: 8'd28,  r: 8'd4,   z: 1'b0};
    vecs[1] = '{n: 8'd255, d: 8'd1,   q: 8'd255, r: 8'd0,   z: 1'b0};
    vecs[2] = '{n: 8'd5,   d: 8'd9,   q: 8'd0,   r: 8'd5,   z: 1'b0};
    vecs[3] = '{n: 8'd0,   d: 8'd13,  q: 8'd0,   r: 8'd0,   z: 1'b0};
    vecs[4] = '{n: 8'd255, d: 8'd255, q: 8'd1,   r: 8'd0,   z: 1'b0};
    vecs[5] = '{n: 8'd100, d: 8'd0,   q: 8'd255, r: 8'd100, z: 1'b1};
    vecs[6] = '{n: 8'd100, d: 8'd10,  q: 8'd10,  r: 8'd0,   z: 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0; dividend = '0; divisor = '0;
    in_valid2 = 1'b0; dividend2 = '0; divisor2 = '0;
    repeat (3) @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset quotient", 32'(quotient), 32'd0);
    chk("reset remainder", 32'(remainder), 32'd0);
    chk("reset dbz", 32'(div_by_zero), 32'd0);
    chk("reset out_valid16", 32'(out_valid2), 32'd0);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 7; i++) run_single(vecs[i]);

    // Streaming: 16 valid ops mixed with random bubbles
    begin
      int nv;
      int len;
      nv = 0;
      while (nv < 16) begin
        logic v;
        v = ($urandom_range(0, 9) < 7);
        vpat.push_back(v);
        npat.push_back(W'($urandom_range(0, 255)));
        dpat.push_back(W'($urandom_range(1, 255)));
        if (v) nv++;
      end
      len = vpat.size();
      for (int i = 0; i < len + int'(LAT) + 2; i++) begin
        @(negedge clk);
        if (i >= int'(LAT) && (i - int'(LAT)) < len) begin
          int idx;
          idx = i - int'(LAT);
          chk($sformatf("stream valid[%0d]", idx), 32'(out_valid), 32'(vpat[idx]));
          if (vpat[idx] && out_valid) begin
            chk($sformatf("stream q[%0d]", idx), 32'(quotient), 32'(npat[idx] / dpat[idx]));
            chk($sformatf("stream r[%0d]", idx), 32'(remainder), 32'(npat[idx] % dpat[idx]));
            chk($sformatf("stream inv[%0d]", idx),
                32'(32'(quotient) * 32'(dpat[idx]) + 32'(remainder)), 32'(npat[idx]));
            chk($sformatf("stream r<d[%0d]", idx), 32'(remainder < dpat[idx]), 32'd1);
            chk($sformatf("stream dbz[%0d]", idx), 32'(div_by_zero), 32'd0);
          end
        end else begin
          chk($sformatf("stream idle[%0d]", i), 32'(out_valid), 32'd0);
        end
        if (i < len) begin
          in_valid = vpat[i]; dividend = npat[i]; divisor = dpat[i];
        end else begin
          in_valid = 1'b0;
        end
      end
    end

    // Reset while five operations are in flight
    begin
      logic seen;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        in_valid = 1'b1;
        dividend = W'(20 + i * 30);
        divisor  = W'(3 + i);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midreset out_valid", 32'(out_valid), 32'd0);
      chk("midreset quotient", 32'(quotient), 32'd0);
      chk("midreset remainder", 32'(remainder), 32'd0);
      chk("midreset dbz", 32'(div_by_zero), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        seen = seen | out_valid;
      end
      chk("midreset no_stale_valid", 32'(seen), 32'd0);
      run_single('{n: 8'd50, d: 8'd6, q: 8'd8, r: 8'd2, z: 1'b0});
    end

    // Round-trip on the 16-bit instance: (a*b)/b == a, remainder 0
    begin
      int bs[4];
      int total;
      int got;
      int exp_a[$];
      bs = '{1, 3, 17, 255};
      total = 256 * 4;
      got = 0;
      for (int i = 0; i < total + int'(LAT2) + 2; i++) begin
        @(negedge clk);
        if (out_valid2) begin
          int a;
          if (exp_a.size() == 0) begin
            chk("roundtrip unexpected_valid", 32'd1, 32'd0);
          end else begin
            a = exp_a.pop_front();
            chk($sformatf("roundtrip q a=%0d", a), 32'(quotient2), 32'(a));
            chk($sformatf("roundtrip r a=%0d", a), 32'(remainder2), 32'd0);
            got++;
          end
        end
        if (i < total) begin
          int a;
          int b;
          a = i % 256;
          b = bs[i / 256];
          in_valid2 = 1'b1;
          dividend2 = W2'(a * b);
          divisor2  = W2'(b);
          exp_a.push_back(a);
        end else begin
          in_valid2 = 1'b0;
        end
      end
      chk("roundtrip count", 32'(got), 32'(total));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
